// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction bus widths and the fetch FSM state type.
package cpu_pkg;
  localparam int INSTR_ADDR_W = 7;
  localparam int INSTR_DATA_W = 16;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CAPTURE} fetch_state_t;
endpackage

// File: rtl/fetch_lat_ctr.sv
// Two-bit loadable down-counter that times the ROM latency wait; zero_o flags expiry.
module fetch_lat_ctr (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [1:0] load_val_i,
  input  logic       dec_i,
  output logic       zero_o
);
  logic [1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)     cnt_d = load_val_i;
    else if (dec_i) cnt_d = cnt_q - 2'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= 2'd0;
    else       cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == 2'd0);
endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: samples the PC on request, reads the synchronous ROM,
// loads IR and pulses pc_up so the PC advances.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = INSTR_ADDR_W,
  parameter int DATA_W  = INSTR_DATA_W,
  parameter int ROM_LAT = 1
) (
  input  logic              Clk,
  input  logic              Clr,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic              fetch_req,
  input  logic              flush,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_rd,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] IR,
  output logic              ir_valid,
  output logic              pc_up,
  output logic              busy,
  output logic              last_fetch
);
  // state   | meaning
  // IDLE    | waiting for fetch_req (blocked during the pc_up cycle)
  // ISSUE   | rom_rd high, ROM samples rom_addr at the ending edge
  // WAIT    | remaining ROM latency, timed by fetch_lat_ctr
  // CAPTURE | rom_data valid, loaded into IR at the ending edge
  if (ROM_LAT < 1 || ROM_LAT > 4) begin : g_bad_lat
    $error("instr_fetch_unit: ROM_LAT must be within 1..4");
  end

  localparam logic [1:0] WAIT_LOAD = (ROM_LAT >= 2) ? 2'(ROM_LAT - 2) : 2'd0;

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] rom_addr_q;
  logic [DATA_W-1:0] ir_q;
  logic              rom_rd_q, ir_valid_q, pc_up_q, last_fetch_q;
  logic              ctr_load, ctr_dec, ctr_zero;

  fetch_lat_ctr u_lat_ctr (
    .clk_i      (Clk),
    .rst_i      (Clr),
    .load_i     (ctr_load),
    .load_val_i (WAIT_LOAD),
    .dec_i      (ctr_dec),
    .zero_o     (ctr_zero)
  );

  always_comb begin
    state_d  = state_q;
    ctr_load = 1'b0;
    ctr_dec  = 1'b0;
    case (state_q)
      IDLE:    if (fetch_req && !pc_up_q) state_d = ISSUE;
      ISSUE: begin
        ctr_load = 1'b1;
        state_d  = (ROM_LAT == 1) ? CAPTURE : WAIT;
      end
      WAIT: begin
        if (ctr_zero) state_d = CAPTURE;
        else          ctr_dec = 1'b1;
      end
      CAPTURE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      state_q      <= IDLE;
      rom_addr_q   <= '0;
      ir_q         <= '0;
      rom_rd_q     <= 1'b0;
      ir_valid_q   <= 1'b0;
      pc_up_q      <= 1'b0;
      last_fetch_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rom_rd_q <= (state_d == ISSUE);
      pc_up_q  <= 1'b0;
      if (state_q == IDLE && state_d == ISSUE) begin
        rom_addr_q   <= mem_addr;
        ir_valid_q   <= 1'b0;
        last_fetch_q <= 1'b0;
      end
      if (state_q == CAPTURE && !flush) begin
        ir_q         <= rom_data;
        ir_valid_q   <= 1'b1;
        pc_up_q      <= 1'b1;
        last_fetch_q <= &rom_addr_q;
      end
      if (flush) ir_valid_q <= 1'b0;
    end
  end

  assign rom_addr   = rom_addr_q;
  assign rom_rd     = rom_rd_q;
  assign IR         = ir_q;
  assign ir_valid   = ir_valid_q;
  assign pc_up      = pc_up_q;
  assign last_fetch = last_fetch_q;
  assign busy       = (state_q != IDLE) || pc_up_q;
endmodule
